xnor_sweep_ctrl: RTL and testbench
==================================

Name: xnor_sweep_ctrl

Overview:
Self-checking sequencer for the three 2-input XNOR implementations (dataflow, behavioural, structural). On start it drives a shared a/b input pair through all four input combinations. It waits a programmable settle time, samples the three c outputs, and compares each against the golden a XNOR b. It reports per-implementation sticky error flags, a mismatch count and a pass/done summary. It sits between a bring-up harness and the gate instances, replacing hand-written stimulus sequences.

Parameters:
SETTLE_CYCLES, 2, cycles held in SETTLE before sampling; 0 allowed (SETTLE skipped)
REPEAT, 1, full 4-vector sweeps per start; must be >= 1
CNT_W, 8, width of err_cnt

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  level-sampled request; honoured only in IDLE
a  out  1  shared gate input a (registered)
b  out  1  shared gate input b (registered)
c_df  in  1  dataflow gate output
c_bh  in  1  behavioural gate output
c_st  in  1  structural gate output
busy  out  1  high from DRIVE through CHECK of the last vector
done  out  1  one-cycle pulse in DONE
pass  out  1  1 when err_cnt == 0 at end of sweep; held until next start
err_cnt  out  CNT_W  total (implementation, vector) mismatches; saturates at all-ones
err_vec  out  3  sticky mismatch flags: [0]=df, [1]=bh, [2]=st
vec_idx  out  2  current vector index; a = vec_idx[1], b = vec_idx[0]

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE. Outputs: a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, err_vec=0, vec_idx=0. Internal settle and sweep counters = 0. Reset overrides everything, including mid-sweep; a partial sweep is discarded.
- IDLE: start=1 at an edge selects DRIVE. At that edge: vec_idx=0, a=0, b=0, err_cnt=0, err_vec=0, pass=0, sweep counter=0, busy=1.
- DRIVE: 1 cycle. a/b are already stable. Next state is SETTLE, or CHECK if SETTLE_CYCLES=0.
- SETTLE: exactly SETTLE_CYCLES cycles, then CHECK.
- CHECK: 1 cycle. Golden value g = ~(a ^ b). At the edge leaving CHECK:
  - each input with c_x != g sets its err_vec bit;
  - err_cnt += number of mismatching inputs (0..3), saturating.
- After CHECK:
  - if vec_idx != 3: vec_idx++, a/b update, next DRIVE;
  - if vec_idx == 3 and sweep counter < REPEAT-1: vec_idx=0, sweep counter++, next DRIVE;
  - otherwise next DONE, busy=0.
- DONE: 1 cycle. done=1, pass=(err_cnt==0) registered at entry, then IDLE. a/b and vec_idx hold their last values.
- Cycles per vector = SETTLE_CYCLES+2. busy high for 4*REPEAT*(SETTLE_CYCLES+2) cycles.
- start ignored in DRIVE, SETTLE, CHECK and DONE. If start is held high, a new sweep begins on the first IDLE cycle.
- err_cnt, err_vec and pass remain valid in IDLE until the next accepted start.

Optional Feature:
XNOR_SWEEP_STOP_ON_ERR_EN
- Defined: any mismatch in CHECK sends the FSM directly to DONE after that CHECK. Remaining vectors and sweeps are skipped, pass=0, and vec_idx holds the failing vector.
- Undefined: the full sweep always runs; mismatches only accumulate.

Test Plan:
- All three gates correct, SETTLE_CYCLES=2, REPEAT=1, start pulse -> a/b step 00,01,10,11, busy high 16 cycles, done pulse next cycle, pass=1, err_cnt=0, err_vec=000.
- c_bh stuck at 0 -> mismatches at 00 and 11: err_cnt=2, err_vec=010, pass=0.
- c_st wired as XOR and c_df stuck at 1 -> st fails all 4 vectors and df fails 01 and 10: err_cnt=6, err_vec=101, pass=0. With XNOR_SWEEP_STOP_ON_ERR_EN defined: done after the first CHECK, vec_idx=0, err_cnt=1, err_vec=100.
- rst_n low for 1 cycle during SETTLE of vector 2 -> next cycle all outputs at reset values and state IDLE. A following start begins at vec_idx=0 with err_cnt=0.
- REPEAT=3, SETTLE_CYCLES=0, start held high continuously -> busy 24 cycles, a/b sequence repeats 3 times, done pulse, one IDLE cycle, then a second sweep starts automatically. start during busy has no effect.
- CNT_W=2, all three gates inverted (XOR) -> err_cnt saturates at 3, err_vec=111, pass=0.

Source files
------------

// File: rtl/xnor_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// xnor_sweep_ctrl
//
// Purpose:
//   Bring-up sequencer for three 2-input XNOR implementations (dataflow,
//   behavioural, structural). When started, it walks the shared a/b pair
//   through 00, 01, 10, 11, repeating the walk REPEAT times. For each vector
//   it holds a/b for SETTLE_CYCLES cycles, then compares each gate output
//   against the golden a XNOR b. Results are reported as sticky
//   per-implementation error flags, a saturating mismatch count and a
//   pass/done summary.
//
// Parameters:
//   SETTLE_CYCLES - cycles spent in SETTLE before sampling (0 skips SETTLE)
//   REPEAT        - number of full 4-vector sweeps per start (>= 1)
//   CNT_W         - width of err_cnt
//
// Optional feature macro:
//   XNOR_SWEEP_STOP_ON_ERR_EN - when defined, the first CHECK that sees any
//   mismatch ends the run immediately (vec_idx holds the failing vector).
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   level-sampled run request, honoured only in IDLE
//   a, b     out  shared gate inputs (registered, = vec_idx[1], vec_idx[0])
//   c_df     in   dataflow gate output
//   c_bh     in   behavioural gate output
//   c_st     in   structural gate output
//   busy     out  high from the first DRIVE through the last CHECK
//   done     out  one-cycle pulse while in DONE
//   pass     out  err_cnt == 0 at end of run, held until next start
//   err_cnt  out  total (implementation, vector) mismatches, saturating
//   err_vec  out  sticky mismatch flags {st, bh, df}
//   vec_idx  out  current vector index
// -----------------------------------------------------------------------------
module xnor_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int REPEAT        = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c_df,
  input  logic             c_bh,
  input  logic             c_st,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       err_vec,
  output logic [1:0]       vec_idx
);

  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW    = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int SUM_W = CNT_W + 2;

  // Last settle count; only meaningful when SETTLE_CYCLES > 0.
  localparam logic [SW-1:0]    SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [RW-1:0]    REPEAT_LAST = RW'(REPEAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [RW-1:0]    sweep_q, sweep_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]       err_vec_q, err_vec_d;

  logic             golden_s;
  logic [2:0]       mm_s;
  logic [1:0]       mm_num_s;
  logic [SUM_W-1:0] sum_s;
  logic [CNT_W-1:0] cnt_sat_s;
  logic             stop_s;

  // Golden compare and saturating mismatch accumulation for the current vector.
  always_comb begin
    golden_s = ~(vec_q[1] ^ vec_q[0]);
    mm_s     = {(c_st != golden_s), (c_bh != golden_s), (c_df != golden_s)};
    mm_num_s = {1'b0, mm_s[0]} + {1'b0, mm_s[1]} + {1'b0, mm_s[2]};
    // Two spare bits so a 0..3 increment cannot wrap even for CNT_W = 1.
    sum_s    = {2'b00, err_cnt_q} + {{CNT_W{1'b0}}, mm_num_s};
    if (sum_s > {2'b00, CNT_MAX}) begin
      cnt_sat_s = CNT_MAX;
    end else begin
      cnt_sat_s = sum_s[CNT_W-1:0];
    end
`ifdef XNOR_SWEEP_STOP_ON_ERR_EN
    stop_s = |mm_s;
`else
    stop_s = 1'b0;
`endif
  end

  // Next-state and next-output logic of the sweep FSM.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    sweep_d   = sweep_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    err_vec_d = err_vec_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_DRIVE;
          vec_d     = 2'd0;
          settle_d  = '0;
          sweep_d   = '0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          err_cnt_d = '0;
          err_vec_d = 3'b000;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        settle_d = '0;
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_CHECK;
          settle_d = '0;
        end else begin
          state_d  = ST_SETTLE;
          settle_d = settle_q + SW'(1);
        end
      end

      ST_CHECK: begin
        err_vec_d = err_vec_q | mm_s;
        err_cnt_d = cnt_sat_s;
        if (stop_s) begin
          // Early exit: vec_idx keeps pointing at the failing vector.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (vec_q != 2'd3) begin
          state_d = ST_DRIVE;
          vec_d   = vec_q + 2'd1;
        end else if (sweep_q < REPEAT_LAST) begin
          state_d = ST_DRIVE;
          vec_d   = 2'd0;
          sweep_d = sweep_q + RW'(1);
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Uses the count including this CHECK's mismatches.
          pass_d  = (cnt_sat_s == {CNT_W{1'b0}});
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= 2'd0;
      settle_q  <= '0;
      sweep_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      err_vec_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      settle_q  <= settle_d;
      sweep_q   <= sweep_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      err_vec_q <= err_vec_d;
    end
  end

  assign a       = vec_q[1];
  assign b       = vec_q[0];
  assign vec_idx = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;
  assign err_vec = err_vec_q;

endmodule

// File: tb/tb_xnor_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xnor_sweep_ctrl
//
// Directed bench for xnor_sweep_ctrl. Three instances:
//   u0 - defaults (SETTLE_CYCLES=2, REPEAT=1, CNT_W=8) with selectable gate
//        faults per implementation
//   u1 - REPEAT=3, SETTLE_CYCLES=0, correct gates, start held high
//   u2 - CNT_W=2, all gates behave as XOR (count saturation)
// -----------------------------------------------------------------------------
module tb_xnor_sweep_ctrl;

`ifdef XNOR_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  // Gate behaviour: 0 correct XNOR, 1 stuck-0, 2 stuck-1, 3 XOR.
  function automatic logic gate(input logic [1:0] mode, input logic ai, input logic bi);
    case (mode)
      2'd0:    return ~(ai ^ bi);
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return ai ^ bi;
    endcase
  endfunction

  // u0
  logic       start0, a0, b0, busy0, done0, pass0;
  logic [1:0] m_df, m_bh, m_st, vec0;
  logic [7:0] err_cnt0;
  logic [2:0] err_vec0;
  logic       c_df0, c_bh0, c_st0;
  assign c_df0 = gate(m_df, a0, b0);
  assign c_bh0 = gate(m_bh, a0, b0);
  assign c_st0 = gate(m_st, a0, b0);

  xnor_sweep_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .c_df(c_df0), .c_bh(c_bh0), .c_st(c_st0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err_cnt0), .err_vec(err_vec0), .vec_idx(vec0)
  );

  // u1
  logic       start1, a1, b1, busy1, done1, pass1;
  logic [1:0] vec1;
  logic [7:0] err_cnt1;
  logic [2:0] err_vec1;
  logic       c1;
  assign c1 = ~(a1 ^ b1);

  xnor_sweep_ctrl #(.SETTLE_CYCLES(0), .REPEAT(3), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .c_df(c1), .c_bh(c1), .c_st(c1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err_cnt1), .err_vec(err_vec1), .vec_idx(vec1)
  );

  // u2
  logic       start2, a2, b2, busy2, done2, pass2;
  logic [1:0] vec2;
  logic [1:0] err_cnt2;
  logic [2:0] err_vec2;
  logic       c2;
  assign c2 = a2 ^ b2;

  xnor_sweep_ctrl #(.SETTLE_CYCLES(2), .REPEAT(1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .c_df(c2), .c_bh(c2), .c_st(c2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err_cnt2), .err_vec(err_vec2), .vec_idx(vec2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One u0 run: start pulse, count busy cycles, record a/b at each DRIVE.
  task automatic run0(output int cyc, output logic [7:0] seq);
    cyc = 0;
    seq = 8'h00;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    while (busy0 && cyc < 200) begin
      if (cyc % 4 == 0) seq = {seq[5:0], a0, b0};
      cyc++;
      tick();
    end
    check_eq("run0_busy_timeout", {31'd0, busy0}, 32'd0);
  endtask

  int          cyc;
  logic [7:0]  seq;
  logic [23:0] seq24;

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    m_df = 2'd0; m_bh = 2'd0; m_st = 2'd0;
    tick(); tick();

    // Reset values
    check_eq("rst_busy",   {31'd0, busy0}, 32'd0);
    check_eq("rst_done",   {31'd0, done0}, 32'd0);
    check_eq("rst_pass",   {31'd0, pass0}, 32'd0);
    check_eq("rst_ab",     {30'd0, a0, b0}, 32'd0);
    check_eq("rst_errcnt", {24'd0, err_cnt0}, 32'd0);
    check_eq("rst_errvec", {29'd0, err_vec0}, 32'd0);
    check_eq("rst_vec",    {30'd0, vec0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: all gates correct
    run0(cyc, seq);
    check_eq("t1_busy_cycles", cyc, 32'd16);
    check_eq("t1_seq",    {24'd0, seq}, 32'h1B);
    check_eq("t1_done",   {31'd0, done0}, 32'd1);
    check_eq("t1_pass",   {31'd0, pass0}, 32'd1);
    check_eq("t1_errcnt", {24'd0, err_cnt0}, 32'd0);
    check_eq("t1_errvec", {29'd0, err_vec0}, 32'd0);
    tick();
    check_eq("t1_done_pulse", {31'd0, done0}, 32'd0);
    check_eq("t1_vec_hold",   {30'd0, vec0}, 32'd3);
    check_eq("t1_ab_hold",    {30'd0, a0, b0}, 32'd3);
    check_eq("t1_pass_hold",  {31'd0, pass0}, 32'd1);

    // Test 2: behavioural gate stuck at 0
    m_bh = 2'd1;
    run0(cyc, seq);
    check_eq("t2_done",   {31'd0, done0}, 32'd1);
    check_eq("t2_errcnt", {24'd0, err_cnt0}, STOP ? 32'd1 : 32'd2);
    check_eq("t2_errvec", {29'd0, err_vec0}, 32'b010);
    check_eq("t2_pass",   {31'd0, pass0}, 32'd0);
    check_eq("t2_busy_cycles", cyc, STOP ? 32'd4 : 32'd16);
    tick();

    // Test 3: structural = XOR, dataflow stuck at 1
    m_bh = 2'd0; m_st = 2'd3; m_df = 2'd2;
    run0(cyc, seq);
    check_eq("t3_done",   {31'd0, done0}, 32'd1);
    check_eq("t3_errcnt", {24'd0, err_cnt0}, STOP ? 32'd1 : 32'd6);
    check_eq("t3_errvec", {29'd0, err_vec0}, STOP ? 32'b100 : 32'b101);
    check_eq("t3_vec",    {30'd0, vec0}, STOP ? 32'd0 : 32'd3);
    check_eq("t3_pass",   {31'd0, pass0}, 32'd0);
    tick();

    // Test 4: reset during SETTLE of vector 2
    m_st = 2'd0; m_df = 2'd0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (9) tick();
    check_eq("t4_pre_vec", {30'd0, vec0}, 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("t4_busy",   {31'd0, busy0}, 32'd0);
    check_eq("t4_ab",     {30'd0, a0, b0}, 32'd0);
    check_eq("t4_vec",    {30'd0, vec0}, 32'd0);
    check_eq("t4_errcnt", {24'd0, err_cnt0}, 32'd0);
    check_eq("t4_errvec", {29'd0, err_vec0}, 32'd0);
    check_eq("t4_done",   {31'd0, done0}, 32'd0);
    tick();
    check_eq("t4_idle", {31'd0, busy0}, 32'd0);
    run0(cyc, seq);
    check_eq("t4_rerun_cycles", cyc, 32'd16);
    check_eq("t4_rerun_seq",  {24'd0, seq}, 32'h1B);
    check_eq("t4_rerun_pass", {31'd0, pass0}, 32'd1);
    tick();

    // Test 5: REPEAT=3, no settle, start held high
    start1 = 1'b1;
    tick();
    cyc   = 0;
    seq24 = 24'd0;
    while (busy1 && cyc < 200) begin
      if (cyc % 2 == 0) seq24 = {seq24[21:0], a1, b1};
      cyc++;
      tick();
    end
    check_eq("t5_busy_cycles", cyc, 32'd24);
    check_eq("t5_seq",    {8'd0, seq24}, 32'h1B1B1B);
    check_eq("t5_done",   {31'd0, done1}, 32'd1);
    check_eq("t5_pass",   {31'd0, pass1}, 32'd1);
    check_eq("t5_errcnt", {24'd0, err_cnt1}, 32'd0);
    tick();
    check_eq("t5_idle_done", {31'd0, done1}, 32'd0);
    check_eq("t5_idle_busy", {31'd0, busy1}, 32'd0);
    tick();
    check_eq("t5_restart_busy", {31'd0, busy1}, 32'd1);
    check_eq("t5_restart_vec",  {30'd0, vec1}, 32'd0);
    start1 = 1'b0;

    // Test 6: CNT_W=2, all gates XOR -> saturation
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 200) begin
      cyc++;
      tick();
    end
    check_eq("t6_busy_timeout", {31'd0, busy2}, 32'd0);
    check_eq("t6_done",   {31'd0, done2}, 32'd1);
    check_eq("t6_errcnt", {30'd0, err_cnt2}, 32'd3);
    check_eq("t6_errvec", {29'd0, err_vec2}, 32'b111);
    check_eq("t6_pass",   {31'd0, pass2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
